hex_display_scan_ctrl: RTL and testbench

- Time-multiplexed controller for the 4-digit 7-segment display that shows two 8-bit values, A and S, as hex.
  - Digit 0 = S[3:0], digit 1 = S[7:4], digit 2 = A[3:0], digit 3 = A[7:4].
- Shares one hex-to-segment decode path across four common-anode digits and scans them round-robin.
- Guard blanking on every digit change prevents ghosting.
- New values come in over a valid/ready handshake and are committed only at frame boundaries, so a frame never shows half-old, half-new data.

---
 rtl/hex_display_scan_ctrl_if.sv | 26 ++
 rtl/hex_display_scan_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_hex_display_scan_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/hex_display_scan_ctrl_if.sv
// Bundle for the hex display scan controller: the A/S load handshake, the
// blank control and the shared segment / digit-enable drive.
`timescale 1ns/1ps
interface hex_display_scan_ctrl_if;
    logic [7:0] hex_in_a;
    logic [7:0] hex_in_s;
    logic       ld_valid;
    logic       ld_ready;
    logic       blank;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame_done;
    logic       committed;

    // Source of A/S pairs and blank; consumer of the display drive.
    modport master (
        output hex_in_a, hex_in_s, ld_valid, blank,
        input  ld_ready, seg, an, frame_done, committed
    );

    // The scan controller itself.
    modport slave (
        input  hex_in_a, hex_in_s, ld_valid, blank,
        output ld_ready, seg, an, frame_done, committed
    );
endinterface

// File: rtl/hex_display_scan_ctrl.sv
// Time-multiplexed 4-digit common-anode 7-segment controller showing two
// bytes A and S in hex (digits 3..0 = A[7:4], A[3:0], S[7:4], S[3:0]).
// Each digit slot opens with GUARD blanked cycles to avoid ghosting. New
// A/S pairs are taken over a valid/ready handshake into shadow registers and
// only copied to the display registers at a frame boundary, so a frame never
// mixes old and new data.
`timescale 1ns/1ps
module hex_display_scan_ctrl #(
    parameter int PRESCALE = 50000,
    parameter int GUARD    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    hex_display_scan_ctrl_if.slave  bus
);

    localparam int             CW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0]  CNT_MAX  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0]  GUARD_W  = CW'(GUARD);

    // Active-low hex to segment decode, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic [1:0]    dig_r;
    logic [1:0]    dig_nxt_s;
    logic [7:0]    a_d_r;
    logic [7:0]    s_d_r;
    logic [7:0]    a_sh_r;
    logic [7:0]    s_sh_r;
    logic          pending_r;
    logic          pending_nxt_s;
    logic          ld_ready_r;
    logic          frame_done_r;
    logic          committed_r;
    logic [6:0]    seg_r;
    logic [6:0]    seg_nxt_s;
    logic [3:0]    an_r;
    logic [3:0]    an_nxt_s;
    logic          wrap_s;
    logic          boundary_s;
    logic          accept_s;
    logic          commit_s;
    logic          in_guard_s;
    logic [3:0]    nibble_s;

    // With no guard the slot is never blanked; avoid a constant compare.
    generate
        if (GUARD == 0) begin : g_no_guard
            assign in_guard_s = 1'b0;
        end else begin : g_guard
            assign in_guard_s = (cnt_r < GUARD_W);
        end
    endgenerate

    // Slot counter and digit pointer; a frame ends on the last cycle of digit 3.
    always_comb begin
        wrap_s     = (cnt_r == CNT_MAX);
        boundary_s = wrap_s && (dig_r == 2'd3);
        if (wrap_s) begin
            cnt_nxt_s = '0;
            dig_nxt_s = dig_r + 2'd1;
        end else begin
            cnt_nxt_s = cnt_r + CW'(1);
            dig_nxt_s = dig_r;
        end
    end

    // Handshake: a commit at the boundary frees the shadow, otherwise an
    // accepted offer fills it. ready is low while pending, so both never coincide.
    always_comb begin
        accept_s = bus.ld_valid && ld_ready_r;
        commit_s = boundary_s && pending_r;
        if (commit_s) begin
            pending_nxt_s = 1'b0;
        end else if (accept_s) begin
            pending_nxt_s = 1'b1;
        end else begin
            pending_nxt_s = pending_r;
        end
    end

    // Next segment/anode drive from the current slot and display registers.
    always_comb begin
        case (dig_r)
            2'd0:    nibble_s = s_d_r[3:0];
            2'd1:    nibble_s = s_d_r[7:4];
            2'd2:    nibble_s = a_d_r[3:0];
            2'd3:    nibble_s = a_d_r[7:4];
            default: nibble_s = 4'h0;
        endcase
        if (in_guard_s || bus.blank) begin
            an_nxt_s  = 4'hF;
            seg_nxt_s = 7'h7F;
        end else begin
            an_nxt_s  = ~(4'b0001 << dig_r);
            seg_nxt_s = hex_to_seg(nibble_s);
        end
    end

    // Scan counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
            dig_r <= 2'd0;
        end else begin
            cnt_r <= cnt_nxt_s;
            dig_r <= dig_nxt_s;
        end
    end

    // Shadow capture, pending flag and ready; a pending pair is lost on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_r     <= 8'h00;
            s_sh_r     <= 8'h00;
            pending_r  <= 1'b0;
            ld_ready_r <= 1'b1;
        end else begin
            if (accept_s) begin
                a_sh_r <= bus.hex_in_a;
                s_sh_r <= bus.hex_in_s;
            end
            pending_r  <= pending_nxt_s;
            ld_ready_r <= ~pending_nxt_s;
        end
    end

    // Display registers, updated only at a frame boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_d_r <= 8'h00;
            s_d_r <= 8'h00;
        end else if (commit_s) begin
            a_d_r <= a_sh_r;
            s_d_r <= s_sh_r;
        end
    end

    // Registered display drive and frame pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r        <= 7'h7F;
            an_r         <= 4'hF;
            frame_done_r <= 1'b0;
            committed_r  <= 1'b0;
        end else begin
            seg_r        <= seg_nxt_s;
            an_r         <= an_nxt_s;
            frame_done_r <= boundary_s;
            committed_r  <= commit_s;
        end
    end

    assign bus.seg        = seg_r;
    assign bus.an         = an_r;
    assign bus.ld_ready   = ld_ready_r;
    assign bus.frame_done = frame_done_r;
    assign bus.committed  = committed_r;

endmodule

// File: tb/tb_hex_display_scan_ctrl.sv
// Directed bench for hex_display_scan_ctrl with PRESCALE=8, GUARD=2.
// A cycle-indexed reference model pushes the expected outputs of every edge
// into a queue; after the edge the entry is popped and compared.
`timescale 1ns/1ps
module tb_hex_display_scan_ctrl;

    localparam int P     = 8;
    localparam int G     = 2;
    localparam int FRAME = 4 * P;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       rdy;
        logic       fd;
        logic       cm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hex_display_scan_ctrl_if bus ();

    hex_display_scan_ctrl #(.PRESCALE(P), .GUARD(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    exp_t       q [$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         k     = 0;
    logic [7:0] m_a, m_s, m_sha, m_shs;
    logic       m_pend;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        k      = 0;
        m_a    = 8'h00;
        m_s    = 8'h00;
        m_sha  = 8'h00;
        m_shs  = 8'h00;
        m_pend = 1'b0;
    endtask

    // One clock: predict the post-edge outputs, clock, then compare.
    task automatic step();
        exp_t       e;
        exp_t       got;
        int         pos;
        int         cnt;
        int         dig;
        logic [3:0] nib;
        pos = k % FRAME;
        cnt = pos % P;
        dig = pos / P;
        if (cnt < G || bus.blank) begin
            e.an  = 4'hF;
            e.seg = 7'h7F;
        end else begin
            case (dig)
                0:       nib = m_s[3:0];
                1:       nib = m_s[7:4];
                2:       nib = m_a[3:0];
                default: nib = m_a[7:4];
            endcase
            e.an  = ~(4'b0001 << dig);
            e.seg = seg_tbl[nib];
        end
        e.fd = (pos == FRAME - 1);
        e.cm = (pos == FRAME - 1) && m_pend;
        if (pos == FRAME - 1 && m_pend) begin
            m_a    = m_sha;
            m_s    = m_shs;
            m_pend = 1'b0;
        end else if (bus.ld_valid && !m_pend) begin
            m_sha  = bus.hex_in_a;
            m_shs  = bus.hex_in_s;
            m_pend = 1'b1;
        end
        e.rdy = !m_pend;
        k++;
        q.push_back(e);
        @(posedge clk);
        #1;
        got.seg = bus.seg;
        got.an  = bus.an;
        got.rdy = bus.ld_ready;
        got.fd  = bus.frame_done;
        got.cm  = bus.committed;
        e = q.pop_front();
        check("seg",        32'(got.seg), 32'(e.seg));
        check("an",         32'(got.an),  32'(e.an));
        check("ld_ready",   32'(got.rdy), 32'(e.rdy));
        check("frame_done", 32'(got.fd),  32'(e.fd));
        check("committed",  32'(got.cm),  32'(e.cm));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < FRAME + 1 && (k % FRAME) != target; i++) step();
    endtask

    task automatic offer(input logic [7:0] a, input logic [7:0] s);
        bus.hex_in_a = a;
        bus.hex_in_s = s;
        bus.ld_valid = 1'b1;
        step();
        bus.ld_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg"}, 32'(bus.seg),        32'h7F);
        check({tag, "_an"},  32'(bus.an),         32'hF);
        check({tag, "_rdy"}, 32'(bus.ld_ready),   32'h1);
        check({tag, "_fd"},  32'(bus.frame_done), 32'h0);
        check({tag, "_cm"},  32'(bus.committed),  32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.hex_in_a = 8'h00;
        bus.hex_in_s = 8'h00;
        bus.ld_valid = 1'b0;
        bus.blank    = 1'b0;
        model_reset();

        // 1: reset values, then idle scanning of 00/00.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        run(2 * FRAME);

        // 2/3: load mid-frame in digit 1, then a second offer while pending.
        run_to(10);
        offer(8'h3C, 8'hA5);
        run(2);
        offer(8'hFF, 8'h00);
        bus.ld_valid = 1'b1;
        run(3);
        bus.ld_valid = 1'b0;
        run_to(0);
        run(FRAME);

        // 4: valid held across the boundary with a pair already pending.
        run_to(20);
        offer(8'h12, 8'h34);
        bus.hex_in_a = 8'h56;
        bus.hex_in_s = 8'h78;
        bus.ld_valid = 1'b1;
        run_to(0);
        step();
        bus.ld_valid = 1'b0;
        run(2 * FRAME + 2);

        // 5: blank for 20 cycles across a commit boundary.
        run_to(5);
        offer(8'h9E, 8'hD7);
        run_to(22);
        bus.blank = 1'b1;
        run(20);
        bus.blank = 1'b0;
        run(FRAME + 4);

        // 6: asynchronous reset in the digit-2 ON phase with a pair pending.
        run_to(17);
        offer(8'hC1, 8'h5B);
        run_to(19);
        rst = 1'b1;
        #2;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        run(2 * FRAME);

        // Decode sweep over all 16 nibbles.
        offer(8'h32, 8'h10);
        run_to(0);
        run(FRAME);
        offer(8'h76, 8'h54);
        run_to(0);
        run(FRAME);
        offer(8'hBA, 8'h98);
        run_to(0);
        run(FRAME);
        offer(8'hFE, 8'hDC);
        run_to(0);
        run(FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
